reset_sequencer: RTL and testbench
==================================

Name: reset_sequencer

Overview:
Parametrised successor to the single-flop power-up reset imitator. Generates N_CH active-high reset outputs, asserted on FPGA configuration, on external reset or on a software request. After a programmable hold time the outputs are released one channel at a time, in index order, with a fixed spacing between channels. Sits between the board clock/reset pins and the design's subsystems (e.g. clock-domain glue, audio codec, display, CPU) that must come out of reset in a defined order.

Parameters:
N_CH, 4, number of reset output channels; must be >= 1.
HOLD_CYCLES, 16, cycles all outputs stay asserted after the reset source goes away; must be >= 1.
STAGE_CYCLES, 4, cycles between release of channel k and channel k+1; must be >= 1.
WDT_CYCLES, 1024, watchdog timeout in cycles; used only with the optional feature.

Ports:
clk  input  1  system clock.
rst_n  input  1  synchronous, active-low reset; sampled on rising clk.
req  input  1  single-cycle software re-sequence request, active high.
kick  input  1  watchdog kick, active high; ignored when the feature is compiled out.
rst_out  output  N_CH  per-channel reset, active high, registered.
done  output  1  high when every channel is released (state RUN).
wdt_fired  output  1  sticky watchdog-timeout flag; constant 0 when the feature is compiled out.

Behaviour:
- FSM states: HOLD, STAGE, RUN. Counters: cnt, sized for max(HOLD_CYCLES, STAGE_CYCLES, WDT_CYCLES). ch_idx, width max(1, $clog2(N_CH)).
- Power-up uses flop initialisers (FPGA only): state=HOLD, cnt=0, ch_idx=0, rst_out=all ones, done=0, wdt_fired=0. The block therefore asserts reset with no external stimulus.
- rst_n=0 at an edge: state=HOLD, cnt=0, ch_idx=0, rst_out=all ones, done=0, wdt_fired=0. This holds for as long as rst_n stays low and has top priority over all other inputs.
- HOLD, rst_n=1:
  - cnt increments each cycle.
  - When cnt==HOLD_CYCLES-1: clear rst_out[0], cnt=0, ch_idx=0.
  - Next state is STAGE if N_CH>1. If N_CH==1, next state is RUN and done=1 on the same edge.
- STAGE:
  - cnt increments each cycle.
  - When cnt==STAGE_CYCLES-1: clear rst_out[ch_idx+1], ch_idx++, cnt=0.
  - If that release was channel N_CH-1: state=RUN and done=1 on the same edge.
- Timing: let edge 0 be the first edge at which rst_n is sampled 1. Channel k drops after edge HOLD_CYCLES-1+k*STAGE_CYCLES, i.e. it is low from cycle HOLD_CYCLES+k*STAGE_CYCLES onward. done rises together with the last channel.
- RUN: outputs stay at rst_out=0, done=1.
- req=1 in any state (rst_n=1): on the next edge state=HOLD, cnt=0, ch_idx=0, rst_out=all ones, done=0. wdt_fired is unchanged. A req during HOLD restarts the hold count; a req during STAGE re-asserts channels already released.
- rst_n=0 together with req=1: the rst_n behaviour applies.
- Reset mid-sequence: any rst_n=0 aborts the sequence immediately; there is no partial release.
- rst_out bits are never released out of index order. At any time the asserted set is a contiguous upper range of channels.

Optional Feature:
Macro RESET_SEQUENCER_WATCHDOG_EN.
- Defined:
  - In RUN, cnt counts up; kick=1 clears cnt to 0.
  - When cnt==WDT_CYCLES-1 with no kick that cycle: wdt_fired<=1 (sticky, cleared only by rst_n=0), and the block re-sequences exactly as for req.
  - The watchdog counter is idle outside RUN.
  - kick together with req: req wins.
- Not defined: kick is unused, wdt_fired is tied 0, and the RUN state holds indefinitely.

Test Plan:
- Power-up (defaults), no rst_n activity, rst_n=1 from time 0: rst_out=4'b1111 for cycles 0..15. Channel 0 is low from cycle 16, channel 1 from 20, channel 2 from 24, channel 3 from 28. done=1 from cycle 28.
- Hold rst_n=0 for 10 cycles, then release: rst_out=4'b1111 and done=0 throughout the low phase. Release pattern as above, counted from the first rst_n=1 edge.
- Assert rst_n=0 at cycle 22 (channels 0 and 1 already released): rst_out=4'b1111 on the next edge, done=0. A full sequence restarts after rst_n returns high.
- Pulse req in RUN: rst_out=4'b1111, done=0 one edge later; the same 16/20/24/28 release pattern follows. A second req at the relative cycle 18 re-asserts channel 0 and restarts the hold.
- N_CH=1, HOLD_CYCLES=1: rst_out drops and done rises after the first edge with rst_n=1.
- With RESET_SEQUENCER_WATCHDOG_EN and WDT_CYCLES=8, kicks every 5 cycles in RUN: no re-sequence. Stop kicking: after 8 kick-free cycles wdt_fired=1, rst_out=all ones, and the sequence replays. wdt_fired stays 1 until rst_n=0.

Source files
------------

// File: rtl/reset_sequencer.sv
// -----------------------------------------------------------------------------
// reset_sequencer
//
// Purpose:
//   Generates N_CH active-high reset outputs. All outputs are asserted at FPGA
//   configuration (flop initial values), while rst_n is low, on a software
//   re-sequence request (req) and, optionally, on a watchdog timeout. After
//   HOLD_CYCLES clean cycles channel 0 is released. The remaining channels
//   are then released one at a time, in index order, STAGE_CYCLES apart.
//
// Ports:
//   clk        in   system clock
//   rst_n      in   synchronous active-low reset, highest priority
//   req        in   single-cycle software re-sequence request
//   kick       in   watchdog kick (ignored unless the watchdog is compiled in)
//   rst_out    out  per-channel reset, active high, registered
//   done       out  high once every channel is released (state RUN)
//   wdt_fired  out  sticky watchdog-timeout flag (0 without the watchdog)
//
// Optional feature:
//   Define RESET_SEQUENCER_WATCHDOG_EN to enable the RUN-state watchdog.
//   Without it, RUN holds until rst_n or req, and wdt_fired stays 0.
// -----------------------------------------------------------------------------
module reset_sequencer #(
    parameter int N_CH         = 4,
    parameter int HOLD_CYCLES  = 16,
    parameter int STAGE_CYCLES = 4,
    parameter int WDT_CYCLES   = 1024
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req,
    input  logic            kick,
    output logic [N_CH-1:0] rst_out,
    output logic            done,
    output logic            wdt_fired
);

    // One counter is shared by the hold, stage and watchdog phases, so it is
    // sized for the largest terminal count of the three.
    localparam int CNT_MAX_HS = (HOLD_CYCLES > STAGE_CYCLES) ? HOLD_CYCLES : STAGE_CYCLES;
    localparam int CNT_MAX    = (CNT_MAX_HS > WDT_CYCLES) ? CNT_MAX_HS : WDT_CYCLES;
    localparam int CNT_W      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam int IDX_W      = (N_CH > 1) ? $clog2(N_CH) : 1;

    localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] STAGE_LAST = CNT_W'(STAGE_CYCLES - 1);
    // ch_idx value at which the next stage release is the final channel.
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'((N_CH >= 2) ? (N_CH - 2) : 0);

    localparam logic [1:0] ST_HOLD  = 2'd0;
    localparam logic [1:0] ST_STAGE = 2'd1;
    localparam logic [1:0] ST_RUN   = 2'd2;

    // Power-up values come from the flop initialisers so the block asserts
    // reset straight out of configuration without any external stimulus.
    logic [1:0]       state_q     = ST_HOLD;
    logic [CNT_W-1:0] cnt_q       = '0;
    logic [IDX_W-1:0] ch_idx_q    = '0;
    logic [N_CH-1:0]  rst_out_q   = '1;
    logic             done_q      = 1'b0;
    logic             wdt_fired_q = 1'b0;

    logic [1:0]       state_d;
    logic [CNT_W-1:0] cnt_d;
    logic [IDX_W-1:0] ch_idx_d;
    logic [N_CH-1:0]  rst_out_d;
    logic             done_d;
    logic             wdt_fired_d;

    // stage_clr[gi] marks the channel released by the current STAGE step:
    // channel ch_idx+1. Channel 0 is only ever released from HOLD.
    logic [N_CH-1:0]  stage_clr;

    genvar gi;
    generate
        for (gi = 0; gi < N_CH; gi++) begin : g_stage_clr
            if (gi == 0) begin : g_ch0
                assign stage_clr[gi] = 1'b0;
            end else begin : g_chn
                assign stage_clr[gi] = (ch_idx_q == IDX_W'(gi - 1));
            end
        end
    endgenerate

`ifndef RESET_SEQUENCER_WATCHDOG_EN
    // kick has no function without the watchdog.
    logic unused_kick;
    assign unused_kick = kick;
`endif

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        ch_idx_d    = ch_idx_q;
        rst_out_d   = rst_out_q;
        done_d      = done_q;
        wdt_fired_d = wdt_fired_q;

        if (req) begin
            // Re-sequence from scratch; wdt_fired is deliberately kept.
            state_d   = ST_HOLD;
            cnt_d     = '0;
            ch_idx_d  = '0;
            rst_out_d = '1;
            done_d    = 1'b0;
        end else begin
            case (state_q)
                ST_HOLD: begin
                    if (cnt_q == HOLD_LAST) begin
                        rst_out_d[0] = 1'b0;
                        cnt_d        = '0;
                        ch_idx_d     = '0;
                        if (N_CH > 1) begin
                            state_d = ST_STAGE;
                        end else begin
                            state_d = ST_RUN;
                            done_d  = 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end

                ST_STAGE: begin
                    if (cnt_q == STAGE_LAST) begin
                        rst_out_d = rst_out_q & ~stage_clr;
                        ch_idx_d  = ch_idx_q + 1'b1;
                        cnt_d     = '0;
                        if (ch_idx_q == IDX_LAST) begin
                            state_d = ST_RUN;
                            done_d  = 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end

                ST_RUN: begin
`ifdef RESET_SEQUENCER_WATCHDOG_EN
                    if (kick) begin
                        cnt_d = '0;
                    end else if (cnt_q == CNT_W'(WDT_CYCLES - 1)) begin
                        // Timeout: flag it and replay the whole sequence.
                        wdt_fired_d = 1'b1;
                        state_d     = ST_HOLD;
                        cnt_d       = '0;
                        ch_idx_d    = '0;
                        rst_out_d   = '1;
                        done_d      = 1'b0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
`endif
                end

                default: begin
                    // Unreachable encoding: recover by restarting the sequence.
                    state_d   = ST_HOLD;
                    cnt_d     = '0;
                    ch_idx_d  = '0;
                    rst_out_d = '1;
                    done_d    = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_HOLD;
            cnt_q       <= '0;
            ch_idx_q    <= '0;
            rst_out_q   <= '1;
            done_q      <= 1'b0;
            wdt_fired_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            ch_idx_q    <= ch_idx_d;
            rst_out_q   <= rst_out_d;
            done_q      <= done_d;
            wdt_fired_q <= wdt_fired_d;
        end
    end

    assign rst_out   = rst_out_q;
    assign done      = done_q;
    // Never set unless the watchdog is compiled in, so it reads as 0 then.
    assign wdt_fired = wdt_fired_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// -----------------------------------------------------------------------------
// tb_reset_sequencer
//
// Drives two reset_sequencer instances from the same inputs: one with the
// default channel/hold/stage settings, one with N_CH=1, HOLD_CYCLES=1. Both
// use WDT_CYCLES=8 so the watchdog build is exercised quickly.
// The reference model tracks only "edges since the sequence started" and an
// idle counter for RUN; the expected outputs follow from the release formula
// (channel k released once pos >= HOLD + k*STAGE).
// -----------------------------------------------------------------------------
module tb_reset_sequencer;

    localparam int N0 = 4;
    localparam int H0 = 16;
    localparam int S0 = 4;
    localparam int W0 = 8;
    localparam int N1 = 1;
    localparam int H1 = 1;
    localparam int S1 = 1;
    localparam int W1 = 8;

`ifdef RESET_SEQUENCER_WATCHDOG_EN
    localparam bit WDT_ON = 1'b1;
`else
    localparam bit WDT_ON = 1'b0;
`endif

    logic          clk   = 1'b0;
    logic          rst_n = 1'b1;
    logic          req   = 1'b0;
    logic          kick  = 1'b0;
    logic [N0-1:0] rst_out0;
    logic          done0;
    logic          wdt0;
    logic [N1-1:0] rst_out1;
    logic          done1;
    logic          wdt1;

    int n_check = 0;
    int n_fail  = 0;

    // Model state: pos = rst_n-high edges since the sequence (re)started,
    // idle = consecutive kick-free RUN edges, fired = sticky watchdog flag.
    int pos0  = 0;
    int idle0 = 0;
    bit fired0 = 1'b0;
    int pos1  = 0;
    int idle1 = 0;
    bit fired1 = 1'b0;

    always #5 clk = ~clk;

    reset_sequencer #(
        .N_CH(N0), .HOLD_CYCLES(H0), .STAGE_CYCLES(S0), .WDT_CYCLES(W0)
    ) u_dut0 (
        .clk(clk), .rst_n(rst_n), .req(req), .kick(kick),
        .rst_out(rst_out0), .done(done0), .wdt_fired(wdt0)
    );

    reset_sequencer #(
        .N_CH(N1), .HOLD_CYCLES(H1), .STAGE_CYCLES(S1), .WDT_CYCLES(W1)
    ) u_dut1 (
        .clk(clk), .rst_n(rst_n), .req(req), .kick(kick),
        .rst_out(rst_out1), .done(done1), .wdt_fired(wdt1)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_check++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s t=%0t got=%0h exp=%0h", tag, $time, got, exp);
        end
    endtask

    function automatic logic [31:0] exp_rst(input int pos, input int hold, input int stage, input int nch);
        logic [31:0] v;
        v = '0;
        for (int k = 0; k < nch; k++) begin
            v[k] = (pos < hold + k * stage);
        end
        return v;
    endfunction

    function automatic logic [31:0] exp_done(input int pos, input int hold, input int stage, input int nch);
        return (pos >= hold + (nch - 1) * stage) ? 32'd1 : 32'd0;
    endfunction

    task automatic model_step(input int hold, input int stage, input int nch, input int wdt,
                              input bit rn, input bit rq, input bit kk,
                              inout int pos, inout int idle, inout bit fired);
        if (!rn) begin
            pos   = 0;
            idle  = 0;
            fired = 1'b0;
        end else if (rq) begin
            pos  = 0;
            idle = 0;
        end else if (pos >= hold + (nch - 1) * stage) begin
            if (!WDT_ON || kk) begin
                idle = 0;
            end else if (idle == wdt - 1) begin
                fired = 1'b1;
                pos   = 0;
                idle  = 0;
            end else begin
                idle++;
            end
        end else begin
            pos++;
        end
    endtask

    task automatic check_all(input string ph);
        check_eq({ph, ".rst0"},  32'(rst_out0), exp_rst(pos0, H0, S0, N0));
        check_eq({ph, ".done0"}, 32'(done0),    exp_done(pos0, H0, S0, N0));
        check_eq({ph, ".wdt0"},  32'(wdt0),     32'(fired0));
        check_eq({ph, ".rst1"},  32'(rst_out1), exp_rst(pos1, H1, S1, N1));
        check_eq({ph, ".done1"}, 32'(done1),    exp_done(pos1, H1, S1, N1));
        check_eq({ph, ".wdt1"},  32'(wdt1),     32'(fired1));
    endtask

    // One transaction = one clock: drive, clock edge, model update, check.
    task automatic cycle(input string ph, input bit rn, input bit rq, input bit kk);
        rst_n = rn;
        req   = rq;
        kick  = kk;
        @(posedge clk);
        model_step(H0, S0, N0, W0, rn, rq, kk, pos0, idle0, fired0);
        model_step(H1, S1, N1, W1, rn, rq, kk, pos1, idle1, fired1);
        @(negedge clk);
        check_all(ph);
        $display("%s t=%0t rst_n=%0d req=%0d kick=%0d | rst0=%b done0=%0d wdt0=%0d | rst1=%b done1=%0d wdt1=%0d",
                 ph, $time, rn, rq, kk, rst_out0, done0, wdt0, rst_out1, done1, wdt1);
    endtask

    initial begin
        // Power-up state before any clock edge.
        #1;
        check_all("powerup");

        // Power-up release with rst_n high from time 0.
        for (int i = 0; i < 40; i++) cycle("pwr", 1'b1, 1'b0, 1'b0);

        // rst_n low for 10 cycles, then a full sequence.
        for (int i = 0; i < 10; i++) cycle("rstlow", 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 40; i++) cycle("rel", 1'b1, 1'b0, 1'b0);

        // Abort mid-sequence at relative cycle 22 (channels 0,1 released).
        cycle("abort_pre", 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 22; i++) cycle("abort_seq", 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 2; i++) cycle("abort_low", 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 40; i++) cycle("abort_rel", 1'b1, 1'b0, 1'b0);

        // req in RUN, then a second req 18 cycles later, then a full replay.
        cycle("req1", 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 18; i++) cycle("req_seq", 1'b1, 1'b0, 1'b0);
        cycle("req2", 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 40; i++) cycle("req_rel", 1'b1, 1'b0, 1'b0);

        // Watchdog: regular kicks, then stop kicking, then clear with rst_n.
        for (int i = 0; i < 60; i++) cycle("kick", 1'b1, 1'b0, (i % 5) == 0);
        for (int i = 0; i < 50; i++) cycle("nokick", 1'b1, 1'b0, 1'b0);
        cycle("kick_req", 1'b1, 1'b1, 1'b1);
        cycle("wdt_clr", 1'b0, 1'b0, 1'b0);

        // Randomised traffic with alternating kick-heavy and kick-free phases.
        for (int i = 0; i < 2000; i++) begin
            bit rn;
            bit rq;
            bit kk;
            rn = ($urandom_range(63) != 0);
            rq = ($urandom_range(47) == 0);
            kk = ((i / 200) % 2 == 0) ? ($urandom_range(2) == 0) : 1'b0;
            cycle("rand", rn, rq, kk);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_check, n_fail);
        $finish;
    end

endmodule
